// File: rtl/seq_divider.sv
// seq_divider: multi-cycle iterative restoring divider, RISC-V M semantics.
// Produces one quotient bit per cycle after a one-cycle preparation step
// that also resolves divide-by-zero and signed overflow without iterating.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        synchronous active-low reset
//   op_valid     operand pair presented
//   op_ready     block can accept operands (high only when idle)
//   aOperand     dividend
//   bOperand     divisor
//   unsignedEn   1 = unsigned, 0 = two's-complement signed
//   result_valid divResult/remResult are valid
//   result_ready consumer accepts the result
//   divResult    quotient (registered, held after the result handshake)
//   remResult    remainder (registered, held after the result handshake)
module seq_divider #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  op_valid,
   output logic                  op_ready,
   input  logic [DATA_WIDTH-1:0] aOperand,
   input  logic [DATA_WIDTH-1:0] bOperand,
   input  logic                  unsignedEn,
   output logic                  result_valid,
   input  logic                  result_ready,
   output logic [DATA_WIDTH-1:0] divResult,
   output logic [DATA_WIDTH-1:0] remResult
);

   localparam int unsigned CntW = $clog2(DATA_WIDTH);
   localparam logic [DATA_WIDTH-1:0] IntMin = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StPrep, StIter, StDone} state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;      // raw divisor, then |b| once iterating
   logic                  uns_q, uns_d;
   logic [DATA_WIDTH-1:0] rem_q, rem_d;  // partial remainder
   logic [DATA_WIDTH-1:0] quo_q, quo_d;  // dividend shifting out, quotient shifting in
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  negq_q, negq_d;
   logic                  negr_q, negr_d;
   logic [DATA_WIDTH-1:0] div_q, div_d;
   logic [DATA_WIDTH-1:0] remres_q, remres_d;

   logic                  neg_a, neg_b;
   logic [DATA_WIDTH-1:0] abs_a, abs_b;
   logic [DATA_WIDTH:0]   rem_sh, trial;
   logic                  trial_ok;
   logic [DATA_WIDTH-1:0] rem_nx, quo_nx;

   assign neg_a = ~uns_q & a_q[DATA_WIDTH-1];
   assign neg_b = ~uns_q & b_q[DATA_WIDTH-1];
   assign abs_a = neg_a ? -a_q : a_q;
   assign abs_b = neg_b ? -b_q : b_q;

   // One extra bit: the shifted remainder can reach 2*|b|-1, beyond DATA_WIDTH bits.
   assign rem_sh   = {rem_q, quo_q[DATA_WIDTH-1]};
   assign trial    = rem_sh - {1'b0, b_q};
   assign trial_ok = ~trial[DATA_WIDTH];
   assign rem_nx   = trial_ok ? trial[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
   assign quo_nx   = {quo_q[DATA_WIDTH-2:0], trial_ok};

   assign op_ready     = (state_q == StIdle);
   assign result_valid = (state_q == StDone);
   assign divResult    = div_q;
   assign remResult    = remres_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         uns_q    <= 1'b0;
         rem_q    <= '0;
         quo_q    <= '0;
         cnt_q    <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         div_q    <= '0;
         remres_q <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         uns_q    <= uns_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         cnt_q    <= cnt_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         div_q    <= div_d;
         remres_q <= remres_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      uns_d    = uns_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      cnt_d    = cnt_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      div_d    = div_q;
      remres_d = remres_q;

      unique case (state_q)
         StIdle: begin
            if (op_valid) begin
               a_d     = aOperand;
               b_d     = bOperand;
               uns_d   = unsignedEn;
               state_d = StPrep;
            end
         end
         StPrep: begin
            if (b_q == '0) begin
               div_d    = '1;
               remres_d = a_q;
               state_d  = StDone;
            end else if (!uns_q && (a_q == IntMin) && (b_q == '1)) begin
               div_d    = IntMin;
               remres_d = '0;
               state_d  = StDone;
            end else begin
               b_d     = abs_b;
               quo_d   = abs_a;
               rem_d   = '0;
               cnt_d   = '0;
               negq_d  = neg_a ^ neg_b;
               negr_d  = neg_a;
               state_d = StIter;
            end
         end
         StIter: begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
               div_d    = negq_q ? -quo_nx : quo_nx;
               remres_d = negr_q ? -rem_nx : rem_nx;
               state_d  = StDone;
            end
         end
         StDone: begin
            if (result_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: reference model feeds a scoreboard at
// issue time; results are popped and compared when result_valid appears.
module tb_seq_divider;

   localparam int unsigned W = 32;
   localparam logic [W-1:0] IntMin = 32'h8000_0000;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         op_valid = 1'b0;
   logic         op_ready;
   logic [W-1:0] aOperand = '0;
   logic [W-1:0] bOperand = '0;
   logic         unsignedEn = 1'b0;
   logic         result_valid;
   logic         result_ready = 1'b0;
   logic [W-1:0] divResult;
   logic [W-1:0] remResult;

   int n_vec = 0;
   int n_bad = 0;

   logic [W-1:0] exp_div_q[$];
   logic [W-1:0] exp_rem_q[$];
   int           exp_lat_q[$];

   always #5 clk = ~clk;

   seq_divider #(.DATA_WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .op_valid     (op_valid),
      .op_ready     (op_ready),
      .aOperand     (aOperand),
      .bOperand     (bOperand),
      .unsignedEn   (unsignedEn),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .divResult    (divResult),
      .remResult    (remResult)
   );

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Reference: RISC-V M division rules using the simulator's own operators.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic uns,
                        output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
      lat = W + 2;
      if (b == '0) begin
         q = '1; r = a; lat = 2;
      end else if (!uns && a == IntMin && b == '1) begin
         q = IntMin; r = '0; lat = 2;
      end else if (uns) begin
         q = a / b; r = a % b;
      end else begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end
   endtask

   // Issue one op from a negedge, await the result, optionally stall, then handshake.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic uns,
                         input int hold, input logic early_rdy);
      logic [W-1:0] q, r, got_div, got_rem;
      int lat, cyc;
      model(a, b, uns, q, r, lat);
      exp_div_q.push_back(q);
      exp_rem_q.push_back(r);
      exp_lat_q.push_back(lat);
      check("op_ready_idle", {31'b0, op_ready}, 32'd1);
      op_valid = 1'b1; aOperand = a; bOperand = b; unsignedEn = uns;
      result_ready = early_rdy;
      @(posedge clk);
      @(negedge clk);
      op_valid = 1'b0; aOperand = $urandom; bOperand = $urandom; unsignedEn = $urandom;
      cyc = 1;
      while (!result_valid && cyc < 200) begin
         check("op_ready_busy", {31'b0, op_ready}, 32'd0);
         @(negedge clk);
         cyc++;
      end
      check("latency", cyc, exp_lat_q.pop_front());
      check("quotient", divResult, exp_div_q.pop_front());
      check("remainder", remResult, exp_rem_q.pop_front());
      got_div = divResult;
      got_rem = remResult;
      result_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         op_valid = $urandom; aOperand = $urandom; bOperand = $urandom;
         @(negedge clk);
         check("hold_valid", {31'b0, result_valid}, 32'd1);
         check("hold_op_ready", {31'b0, op_ready}, 32'd0);
         check("hold_div", divResult, got_div);
         check("hold_rem", remResult, got_rem);
      end
      op_valid = 1'b0;
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      check("post_hs_valid", {31'b0, result_valid}, 32'd0);
      check("post_hs_ready", {31'b0, op_ready}, 32'd1);
      check("post_hs_div", divResult, got_div);
      check("post_hs_rem", remResult, got_rem);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      repeat (2) @(negedge clk);
      check("rst_op_ready", {31'b0, op_ready}, 32'd1);
      check("rst_valid", {31'b0, result_valid}, 32'd0);
      check("rst_div", divResult, 32'd0);
      check("rst_rem", remResult, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 0, 1'b0);   // -7 / 2 -> -3 r -1
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b0);   // unsigned 0x7FFFFFFC r 1
      run_op(32'd5, 32'd0, 1'b1, 0, 1'b0);
      run_op(32'd5, 32'd0, 1'b0, 0, 1'b0);
      run_op(IntMin, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
      run_op(IntMin, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
      run_op(32'd7, 32'hFFFF_FFFE, 1'b0, 10, 1'b0);  // backpressure, 7 / -2
      run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0, 0, 1'b1); // -100 / -7, ready early
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
      run_op(32'd3, 32'd10, 1'b0, 0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = (i % 2 == 0) ? $urandom : ($urandom & 32'h0000_00FF);
         run_op(ra, rb, i[0], 0, 1'b0);
      end

      // Reset mid-iteration: count==15 is registered after E16, reset lands on E17.
      op_valid = 1'b1; aOperand = 32'd100; bOperand = 32'd7; unsignedEn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      op_valid = 1'b0;
      repeat (16) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("midrst_op_ready", {31'b0, op_ready}, 32'd1);
      check("midrst_valid", {31'b0, result_valid}, 32'd0);
      check("midrst_div", divResult, 32'd0);
      check("midrst_rem", remResult, 32'd0);
      run_op(32'd100, 32'd7, 1'b0, 0, 1'b0);
      check("after_rst_q14", divResult, 32'd14);
      check("after_rst_r2", remResult, 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
